fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with 2-entry buffer, single outstanding request, redirect and HALT
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instruction,
    output logic [15:0] pc_inc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic        err
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_next;
    logic [15:0] pc;
    logic [15:0] buf_instr [2];
    logic [15:0] buf_pcinc [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        outstanding;
    logic        discard;
    logic [15:0] req_pcinc;
    logic        push, pop, halt_word;
    logic [2:0]  occupancy;

    assign instr_valid = (count != 2'd0);
    assign instruction = buf_instr[rd_ptr];
    assign pc_inc      = buf_pcinc[rd_ptr];
    assign imem_addr   = pc;
    assign halted      = (state == HALT) && (count == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // Occupancy is taken after this cycle's pop and a returning response may
    // retire the outstanding slot, so a latency-1 memory streams without gaps.
    always_comb begin
        state_next = state;
        halt_word  = (imem_rdata[15:11] == 5'b00000);
        pop        = instr_valid && instr_ready && !redirect_en;
        push       = imem_rvalid && outstanding && !discard && !redirect_en;
        occupancy  = {1'b0, count} + {2'b00, outstanding} - {2'b00, pop};
        imem_req   = 1'b0;
        if (redirect_en)
            state_next = RUN;
        else if (push && halt_word)
            state_next = HALT;
        if (rst && (state == RUN) && !redirect_en && !(outstanding && !imem_rvalid)
            && !(push && halt_word) && (occupancy < 3'd2))
            imem_req = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= 16'h0000;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            req_pcinc   <= 16'h0000;
            err         <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= 16'h0000;
                buf_pcinc[i] <= 16'h0000;
            end
        end else begin
            err <= err | (imem_rvalid && !outstanding) | (redirect_en && redirect_pc[0]);
            if (redirect_en) begin
                pc          <= {redirect_pc[15:1], 1'b0};
                rd_ptr      <= 1'b0;
                wr_ptr      <= 1'b0;
                count       <= 2'd0;
                // a response landing this very cycle is already dropped here
                outstanding <= outstanding && !imem_rvalid;
                discard     <= outstanding && !imem_rvalid;
            end else begin
                if (imem_req) begin
                    pc        <= pc + 16'd2;
                    req_pcinc <= pc + 16'd2;
                end
                if (push) begin
                    buf_instr[wr_ptr] <= imem_rdata;
                    buf_pcinc[wr_ptr] <= req_pcinc;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
                if (imem_req)
                    outstanding <= 1'b1;
                else if (imem_rvalid)
                    outstanding <= 1'b0;
                if (imem_rvalid)
                    discard <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic [15:0] instruction;
    logic [15:0] pc_inc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    logic        mem_on, halt_mode, pend;
    logic [15:0] pend_addr;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .pc_inc      (pc_inc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_mode && a == 16'h0004) return 16'h0000;
        return 16'h4000 + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // latency-1 memory: a request seen before the edge is answered in the next cycle
    task automatic tick();
        pend      = imem_req;
        pend_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = mem_on && pend;
        imem_rdata  = mem_word(pend_addr);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_rvalid = 1'b0;
        redirect_en = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0; redirect_en = 1'b0;
        redirect_pc = 16'h0; instr_ready = 1'b1; mem_on = 1'b1; halt_mode = 1'b0;
        pend = 1'b0; pend_addr = 16'h0;
        #1;
        tick(); tick(); #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // streaming
        rst = 1'b1; #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'h0000);
        tick(); #1;
        chk("nobypass_valid", 32'(instr_valid), 32'd0);
        chk("c1_addr", 32'(imem_addr), 32'h0002);
        tick();
        for (int k = 2; k < 10; k++) begin
            #1;
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_instr", 32'(instruction), 32'(16'h4000 + 2 * (k - 2)));
            chk("stream_pcinc", 32'(pc_inc), 32'(2 * (k - 2) + 2));
            chk("stream_req", 32'(imem_req), 32'd1);
            chk("stream_addr", 32'(imem_addr), 32'(2 * k));
            chk("stream_err", 32'(err), 32'd0);
            tick();
        end

        // backpressure
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i >= 3) chk("bp_noreq", 32'(imem_req), 32'd0);
            tick();
        end
        #1;
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_head", 32'(instruction), 32'h4000);
        chk("bp_head_pcinc", 32'(pc_inc), 32'h0002);
        instr_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("bp_rel_valid", 32'(instr_valid), 32'd1);
            chk("bp_rel_instr", 32'(instruction), 32'(16'h4000 + 2 * j));
            tick();
        end

        // redirect with the 0x0006 response arriving in the same cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            tick();
        end
        redirect_en = 1'b1; redirect_pc = 16'h0100; #1;
        chk("redir_noreq", 32'(imem_req), 32'd0);
        tick();
        redirect_en = 1'b0; #1;
        chk("redir_flushed", 32'(instr_valid), 32'd0);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h0100);
        tick(); #1;
        chk("redir_c6_valid", 32'(instr_valid), 32'd0);
        tick(); #1;
        chk("redir_instr", 32'(instruction), 32'h4100);
        chk("redir_pcinc", 32'(pc_inc), 32'h0102);
        chk("redir_err", 32'(err), 32'd0);

        // redirect while a slow response is still in flight
        mem_on = 1'b0;
        do_reset(); #1;
        chk("disc_req0", 32'(imem_req), 32'd1);
        tick(); #1;
        chk("disc_one_out", 32'(imem_req), 32'd0);
        redirect_en = 1'b1; redirect_pc = 16'h0200; #1;
        tick();
        redirect_en = 1'b0; #1;
        chk("disc_wait", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 16'h1234; #1;
        chk("disc_newaddr", 32'(imem_addr), 32'h0200);
        chk("disc_newreq", 32'(imem_req), 32'd1);
        tick(); #1;
        chk("disc_dropped", 32'(instr_valid), 32'd0);
        chk("disc_err", 32'(err), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 16'h5555; #1;
        chk("disc_req2", 32'(imem_addr), 32'h0202);
        tick(); #1;
        chk("disc_instr", 32'(instruction), 32'h5555);
        chk("disc_pcinc", 32'(pc_inc), 32'h0202);
        mem_on = 1'b1;

        // HALT at 0x0004
        halt_mode = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            #1;
            tick();
        end
        #1;
        chk("halt_instr2", 32'(instruction), 32'h4002);
        chk("halt_noreq", 32'(imem_req), 32'd0);
        tick(); #1;
        chk("halt_word", 32'(instruction), 32'h0000);
        chk("halt_pcinc", 32'(pc_inc), 32'h0006);
        chk("halt_not_yet", 32'(halted), 32'd0);
        chk("halt_noreq2", 32'(imem_req), 32'd0);
        tick(); #1;
        chk("halted", 32'(halted), 32'd1);
        chk("halt_empty", 32'(instr_valid), 32'd0);
        tick(); #1;
        chk("halt_noreq3", 32'(imem_req), 32'd0);
        redirect_en = 1'b1; redirect_pc = 16'h0020; #1;
        tick();
        redirect_en = 1'b0; #1;
        chk("unhalt", 32'(halted), 32'd0);
        chk("unhalt_req", 32'(imem_req), 32'd1);
        chk("unhalt_addr", 32'(imem_addr), 32'h0020);
        tick(); #1;
        tick(); #1;
        chk("unhalt_instr", 32'(instruction), 32'h4020);
        halt_mode = 1'b0;

        // protocol error: response with nothing outstanding
        instr_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            #1;
            tick();
        end
        #1;
        chk("err_clear", 32'(err), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 16'h7777; #1;
        tick(); #1;
        chk("err_set", 32'(err), 32'd1);
        chk("err_nopush", 32'(instruction), 32'h4000);
        tick(); tick(); tick(); #1;
        chk("err_sticky", 32'(err), 32'd1);
        rst = 1'b0; #1;
        chk("err_async_clr", 32'(err), 32'd0);
        chk("rst_async_valid", 32'(instr_valid), 32'd0);
        chk("rst_async_req", 32'(imem_req), 32'd0);
        tick();
        rst = 1'b1; #1;
        tick();
        rst = 1'b0; #1;
        chk("abandon_err", 32'(err), 32'd0);
        tick();
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 16'h4000; #1;
        tick(); #1;
        chk("late_rvalid_err", 32'(err), 32'd1);

        // wrap and odd redirect target
        instr_ready = 1'b1;
        do_reset();
        redirect_en = 1'b1; redirect_pc = 16'hFFFE; #1;
        chk("wrap_noreq", 32'(imem_req), 32'd0);
        tick();
        redirect_en = 1'b0; #1;
        chk("wrap_addr0", 32'(imem_addr), 32'hFFFE);
        tick(); #1;
        chk("wrap_addr1", 32'(imem_addr), 32'h0000);
        tick(); #1;
        chk("wrap_instr", 32'(instruction), 32'h3FFE);
        chk("wrap_pcinc", 32'(pc_inc), 32'h0000);
        chk("wrap_err", 32'(err), 32'd0);
        redirect_en = 1'b1; redirect_pc = 16'h0031; #1;
        tick();
        redirect_en = 1'b0; #1;
        chk("odd_err", 32'(err), 32'd1);
        chk("odd_req", 32'(imem_req), 32'd1);
        chk("odd_addr", 32'(imem_addr), 32'h0030);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
